// File: rtl/demux_vc_id_nch.sv
// -----------------------------------------------------------------------------
// demux_vc_id_nch
//
// N-channel virtual-channel demultiplexer placed between an arbiter/source and
// a bank of per-VC FIFOs. Each accepted input word is routed to the VC named
// by a bit field inside the word. A push is never issued towards a VC whose
// FIFO reports almost-full. Instead the word is parked in a one-entry hold
// register and upstream is stalled until that VC drains. A saturating push
// counter per VC is kept for monitoring.
//
// Ports
//   clk                   clock, all state updates on the rising edge
//   reset_L               asynchronous active-low reset
//   demux_vcid_in         input word (BW bits)
//   demux_vcid_valid_in   input word valid
//   demux_vcid_ready_out  registered ready; a word is accepted on valid & ready
//   vc_almost_full_in     per-VC almost-full, bit k = VC k
//   data_out_vc           flattened VC outputs, VC k at [k*BW +: BW]
//   valid_out_vc          per-VC one-cycle push strobe (at most one bit set)
//   push_cnt_vc           flattened saturating push counts, VC k at [k*CNT_W +: CNT_W]
//   hold_busy             a word is parked in the hold register
// -----------------------------------------------------------------------------
module demux_vc_id_nch #(
  parameter int BW       = 6,
  parameter int NUM_VC   = 2,
  // Derived from NUM_VC; leave at its default.
  parameter int VCID_W   = $clog2(NUM_VC),
  parameter int VCID_LSB = BW - VCID_W,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic [BW-1:0]           demux_vcid_in,
  input  logic                    demux_vcid_valid_in,
  output logic                    demux_vcid_ready_out,
  input  logic [NUM_VC-1:0]       vc_almost_full_in,
  output logic [NUM_VC*BW-1:0]    data_out_vc,
  output logic [NUM_VC-1:0]       valid_out_vc,
  output logic [NUM_VC*CNT_W-1:0] push_cnt_vc,
  output logic                    hold_busy
);

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [NUM_VC-1:0] VC_ONE = {{(NUM_VC-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic [BW-1:0]            hold_data_q, hold_data_d;
  logic [VCID_W-1:0]        hold_vc_q, hold_vc_d;
  logic [NUM_VC-1:0]        valid_q, valid_d;
  logic [NUM_VC*BW-1:0]     data_q, data_d;
  logic [NUM_VC*CNT_W-1:0]  cnt_q, cnt_d;

  logic [VCID_W-1:0]        in_vc;
  logic                     accept;
  logic                     in_af;
  logic                     hold_af;

  // Single push port shared by the pass-through and release paths; at most
  // one of them can be active in a given cycle.
  logic                     push_en;
  logic [VCID_W-1:0]        push_vc;
  logic [BW-1:0]            push_data;

  assign in_vc   = demux_vcid_in[VCID_LSB +: VCID_W];
  // ready_q is only ever 1 in PASS, so this alone qualifies an accept.
  assign accept  = demux_vcid_valid_in & ready_q;
  assign in_af   = vc_almost_full_in[in_vc];
  // In HOLD only the parked word's VC matters; other almost-full bits are ignored.
  assign hold_af = vc_almost_full_in[hold_vc_q];

  // ---------------------------------------------------------------------------
  // State register (and all other flops)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_PASS;
      ready_q     <= 1'b0;
      hold_data_q <= '0;
      hold_vc_q   <= '0;
      valid_q     <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      hold_data_q <= hold_data_d;
      hold_vc_q   <= hold_vc_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PASS: if (accept && in_af) state_d = ST_HOLD;
      ST_HOLD: if (!hold_af)        state_d = ST_PASS;
      default: state_d = ST_PASS;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_data_d = hold_data_q;
    hold_vc_d   = hold_vc_q;
    push_en     = 1'b0;
    push_vc     = '0;
    push_data   = '0;
    case (state_q)
      ST_PASS: begin
        if (accept) begin
          if (in_af) begin
            hold_data_d = demux_vcid_in;
            hold_vc_d   = in_vc;
          end else begin
            push_en   = 1'b1;
            push_vc   = in_vc;
            push_data = demux_vcid_in;
          end
        end
      end
      ST_HOLD: begin
        if (!hold_af) begin
          push_en   = 1'b1;
          push_vc   = hold_vc_q;
          push_data = hold_data_q;
        end
      end
      default: ;
    endcase

    // Ready follows the state we are heading into. Coming out of reset the
    // state is already PASS, so ready rises on the first clock edge, and the
    // release edge itself never accepts because ready_q is still 0 there.
    ready_d = (state_d == ST_PASS);
    valid_d = push_en ? (VC_ONE << push_vc) : '0;
  end

  // Per-VC output data and saturating counters; each slice only moves when
  // its own VC is pushed.
  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    logic push_here;
    assign push_here = push_en && (push_vc == VCID_W'(gi));

    assign data_d[gi*BW +: BW] = push_here ? push_data : data_q[gi*BW +: BW];

    assign cnt_d[gi*CNT_W +: CNT_W] =
      (push_here && (cnt_q[gi*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
        ? cnt_q[gi*CNT_W +: CNT_W] + CNT_W'(1)
        : cnt_q[gi*CNT_W +: CNT_W];
  end

  assign demux_vcid_ready_out = ready_q;
  assign data_out_vc          = data_q;
  assign valid_out_vc         = valid_q;
  assign push_cnt_vc          = cnt_q;
  assign hold_busy            = (state_q == ST_HOLD);

endmodule

// File: tb/tb_demux_vc_id_nch.sv
// -----------------------------------------------------------------------------
// Testbench for demux_vc_id_nch, configured with 4 VCs, VC-ID in bits [5:4]
// and 2-bit counters so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_demux_vc_id_nch;

  localparam int BW = 6;
  localparam int NV = 4;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset_L;
  logic [BW-1:0]     demux_vcid_in;
  logic              demux_vcid_valid_in;
  logic              demux_vcid_ready_out;
  logic [NV-1:0]     vc_almost_full_in;
  logic [NV*BW-1:0]  data_out_vc;
  logic [NV-1:0]     valid_out_vc;
  logic [NV*CW-1:0]  push_cnt_vc;
  logic              hold_busy;

  demux_vc_id_nch #(
    .BW(BW), .NUM_VC(NV), .VCID_LSB(4), .CNT_W(CW)
  ) dut (
    .clk                  (clk),
    .reset_L              (reset_L),
    .demux_vcid_in        (demux_vcid_in),
    .demux_vcid_valid_in  (demux_vcid_valid_in),
    .demux_vcid_ready_out (demux_vcid_ready_out),
    .vc_almost_full_in    (vc_almost_full_in),
    .data_out_vc          (data_out_vc),
    .valid_out_vc         (valid_out_vc),
    .push_cnt_vc          (push_cnt_vc),
    .hold_busy            (hold_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          vc;
    logic [5:0]  data;
  } exp_t;

  exp_t sb[$];
  int   cnt_model[NV];

  typedef struct {
    logic [5:0] w;
    logic [3:0] af;
    logic [3:0] ev;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a word; the bench states whether it expects the DUT to be ready.
  task automatic offer(input logic [5:0] w, input logic [3:0] af, input bit will_accept);
    int vc;
    demux_vcid_in       = w;
    demux_vcid_valid_in = 1'b1;
    vc_almost_full_in   = af;
    chk("ready_on_offer", 32'(demux_vcid_ready_out), 32'(will_accept));
    if (will_accept) begin
      vc = int'(w[5:4]);
      sb.push_back('{vc: vc, data: w});
      if (cnt_model[vc] < CNT_MAX) cnt_model[vc]++;
    end
  endtask

  task automatic model_clear;
    sb.delete();
    for (int k = 0; k < NV; k++) cnt_model[k] = 0;
  endtask

  task automatic check_counters(input string tag);
    for (int k = 0; k < NV; k++)
      chk($sformatf("%s_cnt%0d", tag, k), 32'(push_cnt_vc[k*CW +: CW]), 32'(cnt_model[k]));
  endtask

  // Scoreboard side: every push strobe must match the oldest outstanding word.
  always @(negedge clk) begin
    if (reset_L === 1'b1 && valid_out_vc != '0) begin
      chk("onehot", 32'($countones(valid_out_vc)), 32'd1);
      for (int k = 0; k < NV; k++) begin
        if (valid_out_vc[k]) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_push: vc=%0d data=0x%0h, none expected at %0t",
                     k, data_out_vc[k*BW +: BW], $time);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("push_vc", 32'(k), 32'(e.vc));
            chk("push_data", 32'(data_out_vc[k*BW +: BW]), 32'(e.data));
            $display("push vc=%0d data=0x%0h (expected vc=%0d data=0x%0h)",
                     k, data_out_vc[k*BW +: BW], e.vc, e.data);
          end
        end
      end
    end
  end

  vec_t vecs[6];

  initial begin
    vecs[0] = '{w: 6'h05, af: 4'b0000, ev: 4'b0001};
    vecs[1] = '{w: 6'h15, af: 4'b0000, ev: 4'b0010};
    vecs[2] = '{w: 6'h25, af: 4'b0000, ev: 4'b0100};
    vecs[3] = '{w: 6'h35, af: 4'b0000, ev: 4'b1000};
    vecs[4] = '{w: 6'h0A, af: 4'b1110, ev: 4'b0001};  // other VCs full: still passes
    vecs[5] = '{w: 6'h3F, af: 4'b0111, ev: 4'b1000};

    model_clear();
    reset_L             = 1'b0;
    demux_vcid_in       = 6'h15;
    demux_vcid_valid_in = 1'b0;
    vc_almost_full_in   = '0;

    // T1: reset with valid toggling
    for (int i = 0; i < 4; i++) begin
      demux_vcid_valid_in = i[0];
      tick();
    end
    chk("rst_ready", 32'(demux_vcid_ready_out), 0);
    chk("rst_valid", 32'(valid_out_vc), 0);
    chk("rst_hold", 32'(hold_busy), 0);
    chk("rst_data", 32'(data_out_vc), 0);
    chk("rst_cnt", 32'(push_cnt_vc), 0);
    demux_vcid_valid_in = 1'b0;
    reset_L = 1'b1;
    #2;
    chk("ready_before_edge", 32'(demux_vcid_ready_out), 0);
    tick();
    chk("ready_after_edge", 32'(demux_vcid_ready_out), 1);
    chk("no_valid_after_rst", 32'(valid_out_vc), 0);

    // T2: table-driven back-to-back pass-through
    for (int i = 0; i < 6; i++) begin
      offer(vecs[i].w, vecs[i].af, 1'b1);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(valid_out_vc), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_data", i), 32'(data_out_vc[int'(vecs[i].w[5:4])*BW +: BW]),
          32'(vecs[i].w));
      $display("vec%0d word=0x%0h af=%b valid=%b", i, vecs[i].w, vecs[i].af, valid_out_vc);
    end
    demux_vcid_valid_in = 1'b0;
    tick();
    chk("t2_idle_valid", 32'(valid_out_vc), 0);
    check_counters("t2");

    // T3/T4: park 0x2A for VC2, upstream waits with 0x01 while af[0] toggles
    offer(6'h2A, 4'b0100, 1'b1);
    tick();
    chk("t3_ready", 32'(demux_vcid_ready_out), 0);
    chk("t3_hold", 32'(hold_busy), 1);
    chk("t3_valid", 32'(valid_out_vc), 0);
    for (int c = 0; c < 3; c++) begin
      offer(6'h01, {3'b010, c[0]}, 1'b0);
      tick();
      chk($sformatf("t4_hold%0d_valid", c), 32'(valid_out_vc), 0);
      chk($sformatf("t4_hold%0d_busy", c), 32'(hold_busy), 1);
    end
    vc_almost_full_in = 4'b0000;
    tick();
    chk("t3_rel_valid", 32'(valid_out_vc), 32'b0100);
    chk("t3_rel_data", 32'(data_out_vc[2*BW +: BW]), 32'h2A);
    chk("t3_rel_busy", 32'(hold_busy), 0);
    offer(6'h01, 4'b0000, 1'b1);
    tick();
    chk("t4_push_valid", 32'(valid_out_vc), 32'b0001);
    chk("t4_push_data", 32'(data_out_vc[0 +: BW]), 32'h01);
    demux_vcid_valid_in = 1'b0;
    tick();
    chk("t4_no_dup", 32'(valid_out_vc), 0);
    chk("vc3_kept", 32'(data_out_vc[3*BW +: BW]), 32'h3F);
    check_counters("t4");

    // T5: counter saturation on VC1
    reset_L = 1'b0;
    model_clear();
    #3;
    reset_L = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      offer(6'h10 + 6'(i), 4'b0000, 1'b1);
      tick();
      chk($sformatf("t5_push%0d", i), 32'(valid_out_vc), 32'b0010);
    end
    demux_vcid_valid_in = 1'b0;
    tick();
    check_counters("t5");

    // T6: reset while a word is parked
    offer(6'h2A, 4'b0100, 1'b1);
    tick();
    chk("t6_hold", 32'(hold_busy), 1);
    demux_vcid_valid_in = 1'b0;
    reset_L = 1'b0;
    #1;
    chk("t6_async_hold", 32'(hold_busy), 0);
    chk("t6_async_ready", 32'(demux_vcid_ready_out), 0);
    chk("t6_async_data", 32'(data_out_vc), 0);
    model_clear();
    vc_almost_full_in = 4'b0000;
    #2;
    reset_L = 1'b1;
    tick();
    chk("t6_ready", 32'(demux_vcid_ready_out), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_quiet%0d", i), 32'(valid_out_vc), 0);
    end
    check_counters("t6");

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
